// File: rtl/reset_sequencer_if.sv
// Soft-reset request/acknowledge handshake between a requester and
// the reset sequencer.
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 4
);
  logic [N_DOMAINS-1:0] soft_req;
  logic                 soft_ack;

  modport master (output soft_req, input soft_ack);
  modport slave  (input soft_req, output soft_ack);
endinterface

// File: rtl/reset_sequencer.sv
// Staggered release of N reset domains from one board reset, with
// per-domain soft-reset service once all domains are running.
module reset_sequencer #(
  parameter int N_DOMAINS = 4,
  parameter int GAP       = 15,
  parameter int HOLD      = 7,
  parameter int W_CTR     =
    (((GAP > HOLD) ? GAP : HOLD) < 1) ? 1 :
    $clog2(((GAP > HOLD) ? GAP : HOLD) + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sys_ok,
  reset_sequencer_if.slave     soft_if,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 seq_done,
  output logic                 busy
);

  localparam int W_IDX =
    (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_STAGGER,
    S_RUN,
    S_SOFT
  } state_t;

  state_t               state_q, state_d;
  logic [W_CTR-1:0]     ctr_q, ctr_d;
  logic [W_IDX-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] mask_q, mask_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      ctr_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    // Losing sys_ok beats any release or ack due on the same edge
    if (!sys_ok) begin
      state_d = S_HOLD;
      ctr_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          state_d = S_STAGGER;
          ctr_d   = W_CTR'(GAP);
          idx_d   = '0;
        end
        S_STAGGER: begin
          if (ctr_q != '0) begin
            ctr_d = ctr_q - 1'b1;
          end else begin
            rst_d[idx_q] = 1'b1;
            ctr_d        = W_CTR'(GAP);
            idx_d        = idx_q + 1'b1;
            if (idx_q == W_IDX'(N_DOMAINS - 1)) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          // Skip the ack cycle so a held request is not re-taken
          if (!ack_q && soft_if.soft_req != '0) begin
            mask_d  = soft_if.soft_req;
            rst_d   = rst_q & ~soft_if.soft_req;
            ctr_d   = W_CTR'(HOLD);
            state_d = S_SOFT;
          end
        end
        S_SOFT: begin
          if (ctr_q != '0) begin
            ctr_d = ctr_q - 1'b1;
          end else begin
            rst_d   = rst_q | mask_q;
            ack_d   = 1'b1;
            state_d = S_RUN;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  assign domain_rst_n     = rst_q;
  assign seq_done         = done_q;
  assign soft_if.soft_ack = ack_q;
  assign busy             = (state_q != S_RUN);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences release of N downstream reset domains (e.g. memory, bus fabric, CPU, peripherals) from one board-level reset, one domain at a time, with a fixed stagger gap.
- Sits after the power-on reset generator. Consumes its rst_n plus a synchronised "system OK" level, such as PLL lock.
- Once all domains are running, services per-domain soft-reset requests with a req/ack handshake.
- Re-runs the full sequence whenever sys_ok drops.

Parameters:
- N_DOMAINS, 4: number of sequenced reset domains (>= 1). Domain 0 is released first.
- GAP, 15: stagger gap; each domain release is GAP+1 cycles after the previous one.
- HOLD, 7: soft reset assertion length is HOLD+1 cycles.
- W_CTR, $clog2(max(GAP,HOLD)+1): counter width; leave at default.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sys_ok  in  1  synchronous level; 0 forces all domains into reset (tie to synchronised PLL lock)
- soft_req  in  N_DOMAINS  per-domain soft reset request mask; level, held until soft_ack
- soft_ack  out  1  one-cycle pulse: soft reset of the latched mask has completed
- domain_rst_n  out  N_DOMAINS  active-low reset per domain; registered, glitch-free
- seq_done  out  1  all domains released, sequence complete
- busy  out  1  high in any state other than S_RUN

Behaviour:
- Async reset (rst_n low), applied immediately with no clock required:
  - state = S_HOLD, idx = 0, ctr = 0.
  - domain_rst_n = all 0, seq_done = 0, soft_ack = 0, busy = 1.
- All outputs are registered. busy may be decoded from the state register.
- S_HOLD:
  - All domains are held in reset.
  - When sys_ok is sampled 1 at edge E0: go to S_STAGGER, ctr <= GAP, idx <= 0.
- S_STAGGER, each edge:
  - If ctr != 0: ctr <= ctr-1.
  - Else: domain_rst_n[idx] <= 1, ctr <= GAP, idx <= idx+1.
  - Resulting timing: domain i is released at edge E0 + (i+1)*(GAP+1).
  - GAP=0: domains release on consecutive edges E1..EN.
- Final release:
  - The release of domain N_DOMAINS-1 happens on the same edge as: state <= S_RUN, seq_done <= 1.
  - Only the final domain's release is visible on that edge; no extra cycle.
- S_RUN:
  - If soft_ack == 0 and soft_req != 0 at an edge: latch mask <= soft_req, clear domain_rst_n bits for that mask (others unchanged), ctr <= HOLD, state <= S_SOFT.
  - soft_req is ignored while soft_ack is high, so the requester has one cycle to drop its request.
  - soft_req is ignored in all other states; requests are not queued.
- S_SOFT, each edge:
  - If ctr != 0: ctr <= ctr-1.
  - Else: set the masked domain_rst_n bits to 1, soft_ack <= 1 (for exactly one cycle), state <= S_RUN.
  - Masked domains are held low for exactly HOLD+1 cycles.
  - seq_done stays 1 throughout; unmasked domains are never disturbed.
- sys_ok = 0 sampled in any state (highest priority):
  - Next edge: state <= S_HOLD, domain_rst_n <= 0, seq_done <= 0, soft_ack <= 0, idx <= 0.
  - Overrides a same-edge release or ack.
  - When sys_ok returns, the sequence restarts from domain 0.
- soft_ack:
  - Cleared on the edge following its assertion.
  - Never asserted if the soft reset is aborted by sys_ok.
- Counter arithmetic:
  - ctr never wraps. W_CTR holds max(GAP,HOLD).
  - idx is $clog2(N_DOMAINS)-wide; minimum 1 bit when N_DOMAINS = 1.

Test Plan:
1. Power-up, N=4, GAP=15, sys_ok=1, deassert rst_n, first edge sampling sys_ok = E0 -> domain_rst_n goes 0001, 0011, 0111, 1111 at E0+16/32/48/64; seq_done and busy=0 both at E0+64; never non-monotonic.
2. GAP=0, N=4 -> domains release on E1, E2, E3, E4; seq_done at E4.
3. In S_RUN, soft_req=4'b0100 held until ack -> domain_rst_n[2] low for exactly 8 cycles (HOLD=7); other bits stay 1; soft_ack is one pulse on the release edge; busy=1 during; request held through the ack cycle is not re-accepted.
4. Drop sys_ok for 1 cycle at E0+40 (domains 0,1 released) -> next edge all 0, seq_done=0; on sys_ok return, restart with domain 0 at E0'+16.
5. Drop sys_ok during S_SOFT -> all domains 0, soft_ack never pulses; after recovery the full stagger sequence repeats.
6. Assert rst_n mid-S_RUN with clk stopped -> domain_rst_n=0, seq_done=0, busy=1 immediately; no clock edge required.
